// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ready data-memory bus between the load/store unit and memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator with lane alignment, extension, stall and fault reporting.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        RW_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              fault,
  load_store_unit_if.master bus
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] t_type;
  logic [1:0] lo;
  logic [1:0] sz;
  logic req, bad_type, mis, legal;
  logic [3:0] strb;
  logic [31:0] wd, lane, ext;
  always_comb begin
    sz = RW_type[1:0];
    req = MemRead | MemWrite;
    bad_type = (MemRead & MemWrite) | (MemRead ? (sz == 2'b11 || RW_type == 3'b110) : (RW_type[2] || sz == 2'b11));
    mis = (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    legal = req & ~bad_type & ~mis;
    stall = rst_n & (state == REQ || (state == IDLE && legal));
    strb = sz == 2'b00 ? 4'b0001 << addr[1:0] : sz == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = sz == 2'b00 ? {4{wdata[7:0]}} : sz == 2'b01 ? {2{wdata[15:0]}} : wdata;
    lane = bus.mem_rdata >> {lo, 3'b000};
    ext = t_type[1:0] == 2'b00 ? {{24{~t_type[2] & lane[7]}}, lane[7:0]} :
          t_type[1:0] == 2'b01 ? {{16{~t_type[2] & lane[15]}}, lane[15:0]} : lane;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      t_type <= '0;
      lo <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wstrb <= '0;
      bus.mem_wdata <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      fault <= 1'b0;
    end else begin
      fault <= 1'b0;
      rdata_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !legal) fault <= 1'b1;
          else if (legal) begin
            state <= REQ;
            cnt <= '0;
            t_type <= RW_type;
            lo <= addr[1:0];
            bus.mem_req <= 1'b1;
            bus.mem_we <= MemWrite;
            bus.mem_addr <= {addr[31:2], 2'b00};
            bus.mem_wstrb <= MemWrite ? strb : 4'b0000;
            bus.mem_wdata <= wd;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            state <= DONE;
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) begin
              rdata <= ext;
              rdata_valid <= 1'b1;
            end
          end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            bus.mem_req <= 1'b0;
            fault <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a behavioural model.
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n, MemRead, MemWrite;
  logic [2:0] RW_type;
  logic [31:0] addr, wdata;
  logic stall, rdata_valid, fault;
  logic [31:0] rdata;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] model_rdata = 0;
  int o_stalls, o_reqs;
  logic o_fault, o_valid, o_we, o_unstable, o_hung;
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0] o_strb;
  load_store_unit_if bus ();
  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .RW_type(RW_type),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .fault(fault), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic legal_f(input logic rd, wr, input logic [2:0] t, input logic [31:0] a);
    int size;
    if (rd && wr) return 0;
    if (rd && !(t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 0;
    if (wr && !(t inside {3'b000, 3'b001, 3'b010})) return 0;
    size = t[1:0] == 0 ? 1 : t[1:0] == 1 ? 2 : 4;
    return (a % size) == 0;
  endfunction
  function automatic logic [31:0] load_f(input logic [2:0] t, input logic [31:0] a, w);
    logic [31:0] s;
    int v;
    s = w >> (8 * (a % 4));
    case (t)
      3'b000: begin v = int'(s % 256); if (v >= 128) v -= 256; return v; end
      3'b001: begin v = int'(s % 65536); if (v >= 32768) v -= 65536; return v; end
      3'b100: return s % 256;
      3'b101: return s % 65536;
      default: return w;
    endcase
  endfunction
  function automatic logic [3:0] strb_f(input logic [2:0] t, input logic [31:0] a);
    return t == 3'b000 ? 4'(1 << (a % 4)) : t == 3'b001 ? ((a % 4) >= 2 ? 4'd12 : 4'd3) : 4'd15;
  endfunction
  function automatic logic [31:0] wdata_f(input logic [2:0] t, input logic [31:0] w);
    return t == 3'b000 ? (w % 256) * 32'h01010101 : t == 3'b001 ? (w % 65536) * 32'h00010001 : w;
  endfunction
  task automatic run_access(input logic rd, wr, input logic [2:0] t, input logic [31:0] a, wd,
                            input int waits, input logic [31:0] word);
    logic prev;
    prev = 1'b0;
    o_stalls = 0; o_reqs = 0; o_fault = 0; o_valid = 0; o_we = 0; o_unstable = 0; o_hung = 1;
    o_addr = 0; o_wdata = 0; o_strb = 0; o_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin RW_type = t; addr = a; wdata = wd; end
      MemRead = (c == 0 || prev) ? rd : 1'b0;
      MemWrite = (c == 0 || prev) ? wr : 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      #1;
      if (bus.mem_req) begin
        o_reqs++;
        if (o_reqs == 1) begin
          o_addr = bus.mem_addr; o_wdata = bus.mem_wdata; o_strb = bus.mem_wstrb; o_we = bus.mem_we;
        end else if ({o_addr, o_wdata, o_strb, o_we} !== {bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we})
          o_unstable = 1;
        if (o_reqs == waits + 1) begin bus.mem_ready = 1'b1; bus.mem_rdata = word; end
      end else bus.mem_ready = 1'($urandom_range(0, 1));
      if (stall) o_stalls++;
      if (fault) o_fault = 1;
      if (rdata_valid) o_valid = 1;
      prev = stall;
      if (c > 0 && !stall && !bus.mem_req) begin o_hung = 0; o_rdata = rdata; break; end
    end
    @(negedge clk);
    MemRead = 0; MemWrite = 0; bus.mem_ready = 0;
  endtask
  task automatic test_reset;
    rst_n = 0; MemRead = 1; MemWrite = 0; RW_type = 3'b010; addr = 0; wdata = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_cmp++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, rdata, rdata_valid, fault} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: req=%b we=%b addr=%h strb=%b wd=%h rdata=%h v=%b f=%b want all 0",
        bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, rdata, rdata_valid, fault);
    end
    @(negedge clk);
    rst_n = 1; MemRead = 0;
    @(negedge clk);
  endtask
  task automatic test_lw;
    run_access(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF);
    model_rdata = 32'hDEADBEEF;
    n_cmp++;
    if (o_addr !== 32'h100 || o_strb !== 4'b0000) begin n_bad++; $display("FAIL lw_bus: addr=%h strb=%b want 00000100 0000", o_addr, o_strb); end
    n_cmp++;
    if (o_stalls !== 2) begin n_bad++; $display("FAIL lw_stall: got %0d want 2", o_stalls); end
    n_cmp++;
    if (o_rdata !== 32'hDEADBEEF || !o_valid) begin n_bad++; $display("FAIL lw_rdata: got %h v=%b want deadbeef v=1", o_rdata, o_valid); end
  endtask
  task automatic test_lb_lbu;
    run_access(1, 0, 3'b000, 32'h103, 0, 0, 32'h80123456);
    n_cmp++;
    if (o_rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb: got %h want ffffff80", o_rdata); end
    run_access(1, 0, 3'b100, 32'h103, 0, 1, 32'h80123456);
    model_rdata = 32'h00000080;
    n_cmp++;
    if (o_rdata !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", o_rdata); end
  endtask
  task automatic test_sh;
    run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 0);
    n_cmp++;
    if (o_wdata !== 32'hABCDABCD || o_strb !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h200) begin
      n_bad++; $display("FAIL sh_bus: wd=%h strb=%b we=%b addr=%h want abcdabcd 1100 1 00000200", o_wdata, o_strb, o_we, o_addr);
    end
    n_cmp++;
    if (o_stalls !== 5 || o_unstable) begin n_bad++; $display("FAIL sh_stall: got %0d unstable=%b want 5 0", o_stalls, o_unstable); end
    n_cmp++;
    if (o_rdata !== model_rdata || o_valid) begin n_bad++; $display("FAIL sh_rdata_hold: got %h v=%b want %h v=0", o_rdata, o_valid, model_rdata); end
  endtask
  task automatic test_illegal;
    logic [2:0] tt [3] = '{3'b010, 3'b010, 3'b011};
    logic [31:0] aa [3] = '{32'h101, 32'h100, 32'h100};
    logic ww [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_access(1, ww[i], tt[i], aa[i], 0, 0, 32'h5555AAAA);
      n_cmp++;
      if (!o_fault || o_reqs !== 0 || o_stalls !== 0 || o_hung) begin
        n_bad++; $display("FAIL illegal_%0d: fault=%b reqs=%0d stalls=%0d hung=%b want 1 0 0 0", i, o_fault, o_reqs, o_stalls, o_hung);
      end
    end
  endtask
  task automatic test_timeout;
    run_access(1, 0, 3'b010, 32'h40, 0, 1000, 0);
    n_cmp++;
    if (o_reqs !== TO || o_stalls !== TO + 1) begin n_bad++; $display("FAIL timeout_len: reqs=%0d stalls=%0d want %0d %0d", o_reqs, o_stalls, TO, TO + 1); end
    n_cmp++;
    if (!o_fault || o_valid || o_rdata !== model_rdata || o_hung) begin
      n_bad++; $display("FAIL timeout_fault: fault=%b v=%b rdata=%h hung=%b want 1 0 %h 0", o_fault, o_valid, o_rdata, o_hung, model_rdata);
    end
  endtask
  task automatic test_reset_mid_req;
    @(negedge clk);
    MemRead = 1; RW_type = 3'b010; addr = 32'h300; bus.mem_ready = 0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL midreq_enter: req=%b want 1", bus.mem_req); end
    rst_n = 0; MemRead = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_req, stall, fault} !== 3'b000) begin n_bad++; $display("FAIL midreq_reset: req/stall/fault=%b want 000", {bus.mem_req, stall, fault}); end
    model_rdata = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.mem_req, fault} !== 2'b00) begin n_bad++; $display("FAIL midreq_after: req/fault=%b want 00", {bus.mem_req, fault}); end
    run_access(1, 0, 3'b010, 32'h300, 0, 1, 32'hCAFEF00D);
    model_rdata = 32'hCAFEF00D;
    n_cmp++;
    if (o_rdata !== 32'hCAFEF00D || !o_valid || o_stalls !== 3) begin
      n_bad++; $display("FAIL midreq_lw: rdata=%h v=%b stalls=%0d want cafef00d 1 3", o_rdata, o_valid, o_stalls);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      int sel, waits, ereq;
      logic rd, wr, lg, tmo;
      logic [2:0] t;
      logic [31:0] a, wd, word;
      sel = $urandom_range(0, 9);
      rd = sel < 5 || sel == 9;
      wr = sel >= 5;
      t = 3'($urandom);
      a = $urandom;
      wd = $urandom;
      word = $urandom;
      waits = $urandom_range(0, TO + 1);
      lg = legal_f(rd, wr, t, a);
      tmo = waits >= TO;
      ereq = tmo ? TO : waits + 1;
      run_access(rd, wr, t, a, wd, waits, word);
      if (lg && rd && !tmo) model_rdata = load_f(t, a, word);
      n_cmp++;
      if (o_fault !== (!lg || tmo) || o_hung) begin n_bad++; $display("FAIL rnd_fault[%0d]: got %b hung=%b want %b", i, o_fault, o_hung, !lg || tmo); end
      n_cmp++;
      if (o_reqs !== (lg ? ereq : 0) || o_stalls !== (lg ? ereq + 1 : 0)) begin
        n_bad++; $display("FAIL rnd_timing[%0d]: reqs=%0d stalls=%0d want %0d %0d", i, o_reqs, o_stalls, lg ? ereq : 0, lg ? ereq + 1 : 0);
      end
      n_cmp++;
      if (o_rdata !== model_rdata || o_valid !== (lg && rd && !tmo)) begin
        n_bad++; $display("FAIL rnd_rdata[%0d]: got %h v=%b want %h v=%b", i, o_rdata, o_valid, model_rdata, lg && rd && !tmo);
      end
      if (lg) begin
        n_cmp++;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== wr || o_unstable ||
            o_strb !== (wr ? strb_f(t, a) : 4'b0000) || (wr && o_wdata !== wdata_f(t, wd))) begin
          n_bad++; $display("FAIL rnd_bus[%0d]: addr=%h we=%b strb=%b wd=%h unstable=%b want %h %b %b %h", i, o_addr, o_we, o_strb,
            o_wdata, o_unstable, {a[31:2], 2'b00}, wr, wr ? strb_f(t, a) : 4'b0000, wdata_f(t, wd));
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_lw;
    test_lb_lbu;
    test_sh;
    test_illegal;
    test_timeout;
    test_reset_mid_req;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit sitting in the MEM stage behind `main_control`. It consumes the decoded `MemRead`/`MemWrite`/`RW_type` strobes and acts as the initiator on a simple req/ready data-memory bus. It performs byte-lane alignment, write-strobe generation and load sign/zero extension, and stalls the pipeline until the bus access completes. Misaligned, illegal and timed-out accesses are reported through a fault pulse.

## Interface
- `TIMEOUT`, default 16: REQ-state cycles to wait for `mem_ready` before aborting; 0 disables the timeout.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `MemRead` in 1: load request from `main_control`.
- `MemWrite` in 1: store request from `main_control`.
- `RW_type` in 3: func3 of the access. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data (rs2 value).
- `stall` out 1: hold the pipeline; combinational.
- `rdata` out 32: extended load result; registered.
- `rdata_valid` out 1: one-cycle pulse when `rdata` is updated by a load.
- `fault` out 1: one-cycle pulse on misaligned, illegal or timed-out access.
- `mem_req` out 1: bus request; registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, i.e. `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte write enables; 0000 on reads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ready` in 1: bus completion; sampled only while `mem_req`=1.
- `mem_rdata` in 32: read word; valid in the `mem_ready` cycle.

## Operation
**FSM states:** IDLE, REQ, DONE.

**IDLE, request present (`MemRead|MemWrite`):**
- Check legality:
  - Illegal if both strobes are high.
  - Illegal load `RW_type` is any value in {011, 110, 111}.
  - Illegal store `RW_type` is any value other than 000, 001 or 010.
  - Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠00.
- Illegal or misaligned access: `fault` pulses next cycle, no bus request, `stall`=0, FSM stays in IDLE.
- Legal access: latch `we`, `RW_type`, `addr[1:0]`, `mem_addr`, `mem_wstrb` and `mem_wdata`. `stall`=1 this cycle; go to REQ.

**REQ:**
- `mem_req`=1 and `stall`=1.
- All bus outputs are held stable until `mem_ready`.
- On `mem_ready`:
  - Load: capture the formatted `mem_rdata` into `rdata`.
  - Go to DONE.
- Timeout: if `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without `mem_ready`:
  - Drop `mem_req`.
  - Go to DONE with `fault`.
  - `rdata` is left unchanged.

**DONE:**
- `stall`=0 and `mem_req`=0.
- `rdata_valid` pulses for a successful load; `fault` pulses for a timeout.
- Always go to IDLE.
- A request arriving during DONE belongs to the retiring instruction and is ignored.

**Store formatting:**
- sb: `mem_wdata`=`{4{wdata[7:0]}}`, `mem_wstrb`=`0001<<addr[1:0]`.
- sh: `mem_wdata`=`{2{wdata[15:0]}}`, `mem_wstrb`=0011 if `addr[1]`=0, else 1100.
- sw: `mem_wdata`=`wdata`, `mem_wstrb`=1111.

**Load formatting:**
- Select lane `mem_rdata >> (8*addr[1:0])`.
- lb/lh: sign-extend bit 7/15.
- lbu/lhu: zero-extend.
- lw: the full word.

## Timing
- **Reset:** `rst_n`=0 at an edge sets, on that edge:
  - FSM to IDLE, timeout counter to 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wstrb`=0, `mem_wdata`=0.
  - `rdata`=0, `rdata_valid`=0, `fault`=0.
- **Reset during REQ:** the in-flight access is abandoned with no fault.
- **`stall` while in reset:** `stall`=0.
- **Fast accept path:** accept at cycle T (IDLE, `stall`=1); `mem_req`=1 at T+1; `mem_ready` at T+1.
  - DONE at T+2 with `stall`=0; `rdata` and `rdata_valid` valid at T+2.
  - Minimum is 2 stall cycles.
- **Slower bus:** each extra wait cycle adds one stall cycle.
- **Timeout:** `TIMEOUT`=N with no ready gives N REQ cycles; `fault` asserts in the following DONE cycle.
- **Misaligned fault:** access at T gives `fault`=1 at T+1, with zero stall.
- **`mem_ready` outside REQ:** ignored.
- **`rdata` hold:** `rdata` holds its value between loads; stores never modify it.

## Test plan
- **lw:** `addr`=0x100, bus returns 0xDEADBEEF with 0 waits → `mem_addr`=0x100, `mem_wstrb`=0000, `stall` high 2 cycles, `rdata`=0xDEADBEEF with `rdata_valid` pulse.
- **lb/lbu:** `addr`=0x103 and `mem_rdata`=0x80123456 → lb gives `rdata`=0xFFFFFF80; lbu at the same address gives 0x00000080.
- **sh:** `addr`=0x202, `wdata`=0x1234ABCD → `mem_wdata`=0xABCDABCD, `mem_wstrb`=1100, `mem_we`=1; 3 wait cycles → `stall` high 5 cycles.
- **Misaligned:** lw at 0x101 → `fault` pulse next cycle, `mem_req` never asserts, `stall`=0. Same result for `MemRead`=`MemWrite`=1 and for load `RW_type`=011.
- **Timeout:** `TIMEOUT`=4 with `mem_ready` held 0 → `mem_req` high exactly 4 cycles, then `fault` pulse, `rdata` unchanged, back to IDLE.
- **Reset mid-REQ:** `rst_n`=0 during REQ → next edge `mem_req`=0, `stall`=0, `fault`=0; a subsequent lw completes normally.
